// File: rtl/lcd_ctrl_if.sv
// Software-side LCD output word and the controller's LCD pin and status signals.
interface lcd_ctrl_if;
  logic [31:0] i_lcd_word;
  logic        o_lcd_on;
  logic        o_lcd_en;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_busy;
  logic        o_lcd_ack;

  modport master (
    output i_lcd_word,
    input  o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data, o_lcd_busy, o_lcd_ack
  );

  modport slave (
    input  i_lcd_word,
    output o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data, o_lcd_busy, o_lcd_ack
  );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780-style write engine: turns each GO toggle in the LCD word into one
// timed setup / enable / hold / execution write cycle with busy and ack status.
module lcd_ctrl #(
  parameter int unsigned T_SETUP_CYC = 4,
  parameter int unsigned T_EN_CYC    = 12,
  parameter int unsigned T_HOLD_CYC  = 4,
  parameter int unsigned T_EXEC_CYC  = 1850,
  parameter int unsigned T_LONG_CYC  = 76000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  lcd_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(T_LONG_CYC + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;

  logic [2:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_go_seen, w_go_nxt;
  logic             r_rs, w_rs_nxt;
  logic [7:0]       r_data, w_data_nxt;
  logic             r_en, w_en_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_ack, w_ack_nxt;
  logic             r_on;

  logic             w_go;
  logic             w_cnt_zero;
  logic [CNT_W-1:0] w_wait_load;
  logic             w_unused;

  assign w_go       = bus.i_lcd_word[10];
  assign w_cnt_zero = (r_cnt == '0);
  assign w_unused   = &{1'b0, bus.i_lcd_word[30:11], bus.i_lcd_word[8]};

  // Clear (0x01) and home (0x02/0x03) need the long execution wait; 0x00 is lumped in.
  assign w_wait_load = (!r_rs && (r_data[7:2] == 6'd0)) ? CNT_W'(T_LONG_CYC - 1)
                                                        : CNT_W'(T_EXEC_CYC - 1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_go_nxt    = r_go_seen;
    w_rs_nxt    = r_rs;
    w_data_nxt  = r_data;
    w_en_nxt    = 1'b0;
    w_busy_nxt  = r_busy;
    w_ack_nxt   = r_ack;
    case (r_state)
      S_IDLE: begin
        if (w_go != r_go_seen) begin
          w_go_nxt    = w_go;
          w_rs_nxt    = bus.i_lcd_word[9];
          w_data_nxt  = bus.i_lcd_word[7:0];
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = CNT_W'(T_SETUP_CYC - 1);
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_cnt_zero) begin
          w_cnt_nxt   = CNT_W'(T_EN_CYC - 1);
          w_en_nxt    = 1'b1;
          w_state_nxt = S_PULSE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (w_cnt_zero) begin
          w_cnt_nxt   = CNT_W'(T_HOLD_CYC - 1);
          w_state_nxt = S_HOLD;
        end else begin
          w_en_nxt  = 1'b1;
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (w_cnt_zero) begin
          w_cnt_nxt   = w_wait_load;
          w_state_nxt = S_EXEC;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_EXEC: begin
        if (w_cnt_zero) begin
          w_busy_nxt  = 1'b0;
          w_ack_nxt   = ~r_ack;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A GO bit already set during reset is absorbed into go_seen and never issues a write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_go_seen <= w_go;
      r_rs      <= 1'b0;
      r_data    <= 8'd0;
      r_en      <= 1'b0;
      r_busy    <= 1'b0;
      r_ack     <= 1'b0;
      r_on      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_go_seen <= w_go_nxt;
      r_rs      <= w_rs_nxt;
      r_data    <= w_data_nxt;
      r_en      <= w_en_nxt;
      r_busy    <= w_busy_nxt;
      r_ack     <= w_ack_nxt;
      r_on      <= bus.i_lcd_word[31];
    end
  end

  assign bus.o_lcd_on   = r_on;
  assign bus.o_lcd_en   = r_en;
  assign bus.o_lcd_rs   = r_rs;
  assign bus.o_lcd_rw   = 1'b0;
  assign bus.o_lcd_data = r_data;
  assign bus.o_lcd_busy = r_busy;
  assign bus.o_lcd_ack  = r_ack;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing parameters and hand-computed expectations.
module tb_lcd_ctrl;

  localparam int unsigned TS = 2;
  localparam int unsigned TE = 3;
  localparam int unsigned TH = 2;
  localparam int unsigned TX = 5;
  localparam int unsigned TL = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lcd_ctrl_if bus();

  lcd_ctrl #(
    .T_SETUP_CYC(TS), .T_EN_CYC(TE), .T_HOLD_CYC(TH),
    .T_EXEC_CYC(TX), .T_LONG_CYC(TL)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_ack;
  logic go;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkw(input logic on, input logic g, input logic rs,
                                      input logic [7:0] d);
    return {on, 20'd0, g, rs, 1'b0, d};
  endfunction

  // Follows one transaction from its request edge until busy drops; optional mid-flight word rewrites.
  task automatic watch(input string tag, input logic exp_rs, input logic [7:0] exp_d,
                       input int exp_busy, input int pj1, input logic [31:0] pw1,
                       input int pj2, input logic [31:0] pw2);
    int   nb = 0, ne = 0, first_en = -1, last_en = -1, bad = 0, j = 0;
    logic first_busy = 1'b0;
    logic done = 1'b0;
    while (!done && j < 200) begin
      @(negedge clk);
      if (j == 0) first_busy = bus.o_lcd_busy;
      if (bus.o_lcd_busy) begin
        nb++;
        if (bus.o_lcd_en) begin
          ne++;
          if (first_en < 0) first_en = j;
          last_en = j;
        end
        if (bus.o_lcd_rs !== exp_rs || bus.o_lcd_data !== exp_d) bad++;
      end else begin
        done = 1'b1;
      end
      if (j == pj1) bus.i_lcd_word = pw1;
      if (j == pj2) bus.i_lcd_word = pw2;
      j++;
    end
    exp_ack = ~exp_ack;
    check({tag, "_done"},     32'(done), 32'd1);
    check({tag, "_start"},    32'(first_busy), 32'd1);
    check({tag, "_busy_len"}, 32'(nb), 32'(exp_busy));
    check({tag, "_en_first"}, 32'(first_en), 32'(TS));
    check({tag, "_en_last"},  32'(last_en), 32'(TS + TE - 1));
    check({tag, "_en_len"},   32'(ne), 32'(TE));
    check({tag, "_stable"},   32'(bad), 32'd0);
    check({tag, "_ack"},      32'(bus.o_lcd_ack), 32'(exp_ack));
    check({tag, "_rw"},       32'(bus.o_lcd_rw), 32'd0);
  endtask

  // Counts EN and busy cycles over an idle window where nothing should happen.
  task automatic quiet(input string tag, input int cycles);
    int ne = 0, nb = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.o_lcd_en)   ne++;
      if (bus.o_lcd_busy) nb++;
    end
    check({tag, "_en"},   32'(ne), 32'd0);
    check({tag, "_busy"}, 32'(nb), 32'd0);
    check({tag, "_ack"},  32'(bus.o_lcd_ack), 32'(exp_ack));
  endtask

  initial begin
    logic [31:0] w0;
    rst = 1'b1;
    go  = 1'b1;
    exp_ack = 1'b0;
    bus.i_lcd_word = mkw(1'b0, go, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_en",   32'(bus.o_lcd_en), 32'd0);
    check("rst_busy", 32'(bus.o_lcd_busy), 32'd0);
    check("rst_ack",  32'(bus.o_lcd_ack), 32'd0);
    check("rst_data", 32'(bus.o_lcd_data), 32'd0);
    check("rst_rs",   32'(bus.o_lcd_rs), 32'd0);
    check("rst_on",   32'(bus.o_lcd_on), 32'd0);
    rst = 1'b0;
    quiet("go_at_rst", 50);

    go = ~go;
    bus.i_lcd_word = mkw(1'b0, go, 1'b1, 8'h41);
    watch("data41", 1'b1, 8'h41, TS + TE + TH + TX, -1, 32'd0, -1, 32'd0);

    @(negedge clk);
    go = ~go;
    bus.i_lcd_word = mkw(1'b0, go, 1'b0, 8'h01);
    watch("clear", 1'b0, 8'h01, TS + TE + TH + TL, -1, 32'd0, -1, 32'd0);

    @(negedge clk);
    go = ~go;
    bus.i_lcd_word = mkw(1'b0, go, 1'b0, 8'h38);
    watch("fnset", 1'b0, 8'h38, TS + TE + TH + TX, -1, 32'd0, -1, 32'd0);

    // Rewrite data and toggle GO during PULSE: current write keeps 0x41, next follows immediately.
    @(negedge clk);
    go = ~go;
    bus.i_lcd_word = mkw(1'b0, go, 1'b1, 8'h41);
    watch("keep41", 1'b1, 8'h41, TS + TE + TH + TX, 3, mkw(1'b0, ~go, 1'b1, 8'hFF), -1, 32'd0);
    go = ~go;
    watch("queued_ff", 1'b1, 8'hFF, TS + TE + TH + TX, -1, 32'd0, -1, 32'd0);

    @(negedge clk);
    go = ~go;
    w0 = mkw(1'b0, go, 1'b1, 8'h42);
    bus.i_lcd_word = w0;
    watch("dbl", 1'b1, 8'h42, TS + TE + TH + TX, 3, mkw(1'b0, ~go, 1'b1, 8'h42), 5, w0);
    quiet("dbl_after", 20);

    // Reset in PULSE aborts without ack; ON bit follows regardless of state.
    @(negedge clk);
    go = ~go;
    bus.i_lcd_word = mkw(1'b1, go, 1'b1, 8'h43);
    for (int j = 0; j <= int'(TS) + 1; j++) begin
      @(negedge clk);
      if (j == 0) check("on_busy", 32'(bus.o_lcd_on), 32'd1);
    end
    check("en_pre_rst", 32'(bus.o_lcd_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_en",   32'(bus.o_lcd_en), 32'd0);
    check("abort_busy", 32'(bus.o_lcd_busy), 32'd0);
    check("abort_ack",  32'(bus.o_lcd_ack), 32'(exp_ack));
    rst = 1'b0;
    quiet("post_abort", 40);

    go = ~go;
    bus.i_lcd_word = mkw(1'b1, go, 1'b1, 8'h44);
    watch("recover", 1'b1, 8'h44, TS + TE + TH + TX, -1, 32'd0, -1, 32'd0);

    @(negedge clk);
    bus.i_lcd_word = mkw(1'b0, go, 1'b1, 8'h44);
    #1;
    check("on_hold", 32'(bus.o_lcd_on), 32'd1);
    @(negedge clk);
    check("on_clear", 32'(bus.o_lcd_on), 32'd0);
    check("on_no_req", 32'(bus.o_lcd_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
